mem_port_arbiter: RTL and testbench

//  Shares the single-port instruction/data memory between the IF fetch and the MEM-stage

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data memory between the IF fetch
// and the MEM-stage load/store. Each access runs over a ready-handshake bus with a timeout,
// returns data with a one-cycle grant pulse, and drives the pipeline hold signals.
// Ports:
//   i_clk, i_rst_n, i_clk_en         clock, async active-low reset, global enable
//   i_if_req/i_if_addr               fetch request; o_if_gnt/o_if_rdata response
//   i_mem_req/we/addr/wdata/be       load/store request; o_mem_gnt/o_mem_rdata response
//   o_bus_req/we/addr/wdata/be       registered bus command; i_bus_ready/i_bus_rdata reply
//   o_pc_wr_en_h, o_if_id_stall_h,
//   o_mem_stall_h                    combinational pipeline holds
//   o_timeout_err                    sticky bus timeout flag
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic [3:0]        i_mem_be,
  output logic              o_mem_gnt,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic [3:0]        o_bus_be,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_pc_wr_en_h,
  output logic              o_if_id_stall_h,
  output logic              o_mem_stall_h,
  output logic              o_timeout_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS_IF,
    S_BUS_MEM,
    S_RESP_IF,
    S_RESP_MEM
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              timeout_hit;

  logic              bus_req_nxt, bus_we_nxt, if_gnt_nxt, mem_gnt_nxt, timeout_err_nxt;
  logic [ADDR_W-1:0] bus_addr_nxt;
  logic [DATA_W-1:0] bus_wdata_nxt, if_rdata_nxt, mem_rdata_nxt;
  logic [3:0]        bus_be_nxt;
  logic              if_stall;

  // Last permitted wait cycle expired without a ready
  assign timeout_hit = (cnt == CNT_LAST) && !i_bus_ready;

  // State register plus all registered outputs; everything freezes while i_clk_en is low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      o_bus_req     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_wdata   <= '0;
      o_bus_be      <= 4'b0000;
      o_if_gnt      <= 1'b0;
      o_mem_gnt     <= 1'b0;
      o_if_rdata    <= '0;
      o_mem_rdata   <= '0;
      o_timeout_err <= 1'b0;
    end else if (i_clk_en) begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      o_bus_req     <= bus_req_nxt;
      o_bus_we      <= bus_we_nxt;
      o_bus_addr    <= bus_addr_nxt;
      o_bus_wdata   <= bus_wdata_nxt;
      o_bus_be      <= bus_be_nxt;
      o_if_gnt      <= if_gnt_nxt;
      o_mem_gnt     <= mem_gnt_nxt;
      o_if_rdata    <= if_rdata_nxt;
      o_mem_rdata   <= mem_rdata_nxt;
      o_timeout_err <= timeout_err_nxt;
    end
  end

  // Next state: MEM wins in IDLE; after a response the served side is masked
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_mem_req)     state_nxt = S_BUS_MEM;
        else if (i_if_req) state_nxt = S_BUS_IF;
      end
      S_BUS_IF: begin
        if (i_bus_ready || timeout_hit) state_nxt = S_RESP_IF;
      end
      S_BUS_MEM: begin
        if (i_bus_ready || timeout_hit) state_nxt = S_RESP_MEM;
      end
      S_RESP_IF: begin
        state_nxt = i_mem_req ? S_BUS_MEM : S_IDLE;
      end
      S_RESP_MEM: begin
        state_nxt = i_if_req ? S_BUS_IF : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and wait counter
  always_comb begin
    cnt_nxt         = cnt;
    bus_req_nxt     = o_bus_req;
    bus_we_nxt      = o_bus_we;
    bus_addr_nxt    = o_bus_addr;
    bus_wdata_nxt   = o_bus_wdata;
    bus_be_nxt      = o_bus_be;
    if_gnt_nxt      = 1'b0;
    mem_gnt_nxt     = 1'b0;
    if_rdata_nxt    = o_if_rdata;
    mem_rdata_nxt   = o_mem_rdata;
    timeout_err_nxt = o_timeout_err;

    if (state == S_BUS_IF || state == S_BUS_MEM) begin
      if (i_bus_ready || timeout_hit) begin
        bus_req_nxt = 1'b0;
        if (timeout_hit) timeout_err_nxt = 1'b1;
        if (state == S_BUS_IF) begin
          if_gnt_nxt   = 1'b1;
          if_rdata_nxt = i_bus_ready ? i_bus_rdata : NOP_INSN;
        end else begin
          mem_gnt_nxt   = 1'b1;
          mem_rdata_nxt = i_bus_ready ? i_bus_rdata : '0;
        end
      end else begin
        cnt_nxt = CNT_W'(cnt + 1'b1);
      end
    end else if (state_nxt == S_BUS_MEM) begin
      // Launch a data access
      bus_req_nxt   = 1'b1;
      bus_we_nxt    = i_mem_we;
      bus_addr_nxt  = i_mem_addr;
      bus_wdata_nxt = i_mem_wdata;
      bus_be_nxt    = i_mem_be;
      cnt_nxt       = '0;
    end else if (state_nxt == S_BUS_IF) begin
      // Launch a full-word instruction read
      bus_req_nxt   = 1'b1;
      bus_we_nxt    = 1'b0;
      bus_addr_nxt  = i_if_addr;
      bus_wdata_nxt = '0;
      bus_be_nxt    = 4'b1111;
      cnt_nxt       = '0;
    end
  end

  // Pipeline holds: a requester is stalled until the cycle its grant is visible
  assign if_stall        = i_if_req & ~o_if_gnt;
  assign o_mem_stall_h   = i_mem_req & ~o_mem_gnt;
  assign o_if_id_stall_h = if_stall | o_mem_stall_h;
  assign o_pc_wr_en_h    = ~o_if_id_stall_h;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants are queued when requests are
// driven and popped when a grant pulse appears; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        pc_wr_en_h;
  logic        if_id_stall_h;
  logic        mem_stall_h;
  logic        timeout_err;

  typedef struct packed {
    logic        is_mem;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_clk_en       (clk_en),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .o_if_gnt       (if_gnt),
    .o_if_rdata     (if_rdata),
    .i_mem_req      (mem_req),
    .i_mem_we       (mem_we),
    .i_mem_addr     (mem_addr),
    .i_mem_wdata    (mem_wdata),
    .i_mem_be       (mem_be),
    .o_mem_gnt      (mem_gnt),
    .o_mem_rdata    (mem_rdata),
    .o_bus_req      (bus_req),
    .o_bus_we       (bus_we),
    .o_bus_addr     (bus_addr),
    .o_bus_wdata    (bus_wdata),
    .o_bus_be       (bus_be),
    .i_bus_ready    (bus_ready),
    .i_bus_rdata    (bus_rdata),
    .o_pc_wr_en_h   (pc_wr_en_h),
    .o_if_id_stall_h(if_id_stall_h),
    .o_mem_stall_h  (mem_stall_h),
    .o_timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Compare a visible grant against the oldest queued expectation
  task automatic expect_grant(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: grant check with empty scoreboard observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      if (e.is_mem) begin
        check({tag, "_mem_gnt"},   64'(mem_gnt),   64'(1));
        check({tag, "_if_gnt"},    64'(if_gnt),    64'(0));
        check({tag, "_mem_rdata"}, 64'(mem_rdata), 64'(e.rdata));
      end else begin
        check({tag, "_if_gnt"},    64'(if_gnt),    64'(1));
        check({tag, "_mem_gnt"},   64'(mem_gnt),   64'(0));
        check({tag, "_if_rdata"},  64'(if_rdata),  64'(e.rdata));
      end
    end
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0040;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0080;
    mem_wdata = 32'h0;
    mem_be    = 4'b1111;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;

    // Reset with both requests high
    step();
    step();
    check("rst_bus_req",   64'(bus_req),     64'(0));
    check("rst_if_gnt",    64'(if_gnt),      64'(0));
    check("rst_mem_gnt",   64'(mem_gnt),     64'(0));
    check("rst_if_rdata",  64'(if_rdata),    64'(0));
    check("rst_mem_rdata", 64'(mem_rdata),   64'(0));
    check("rst_timeout",   64'(timeout_err), 64'(0));
    check("rst_bus_addr",  64'(bus_addr),    64'(0));
    if_req  = 1'b0;
    mem_req = 1'b0;
    rst_n   = 1'b1;
    step();
    check("idle_bus_req", 64'(bus_req), 64'(0));

    // Fetch with three wait cycles
    if_req  = 1'b1;
    if_addr = 32'h0000_0004;
    sb.push_back('{is_mem: 1'b0, rdata: 32'h0050_0093});
    #1 check("if_pc_hold", 64'(pc_wr_en_h), 64'(0));
    step();
    check("if_bus_req",  64'(bus_req),  64'(1));
    check("if_bus_addr", 64'(bus_addr), 64'(32'h4));
    check("if_bus_we",   64'(bus_we),   64'(0));
    for (int i = 0; i < 3; i++) begin
      check("if_wait_pc_hold", 64'(pc_wr_en_h), 64'(0));
      check("if_wait_gnt",     64'(if_gnt),     64'(0));
      step();
    end
    bus_ready = 1'b1;
    bus_rdata = 32'h0050_0093;
    step();
    bus_ready = 1'b0;
    expect_grant("if_fetch");
    check("if_pc_release", 64'(pc_wr_en_h), 64'(1));
    if_req = 1'b0;
    step();
    check("if_gnt_pulse", 64'(if_gnt),  64'(0));
    check("if_bus_idle",  64'(bus_req), 64'(0));

    // Simultaneous fetch and load: load first, fetch follows with no idle cycle
    if_req   = 1'b1;
    if_addr  = 32'h0000_0008;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0100;
    sb.push_back('{is_mem: 1'b1, rdata: 32'hCAFE_0001});
    sb.push_back('{is_mem: 1'b0, rdata: 32'h00A0_0113});
    step();
    check("both_bus_addr", 64'(bus_addr),      64'(32'h100));
    check("both_if_stall", 64'(if_id_stall_h), 64'(1));
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFE_0001;
    step();
    bus_ready = 1'b0;
    expect_grant("both_load");
    mem_req = 1'b0;
    #1 check("both_if_stall_resp", 64'(if_id_stall_h), 64'(1));
    check("both_mem_stall_resp", 64'(mem_stall_h), 64'(0));
    step();
    check("both_fetch_bus_req",  64'(bus_req),  64'(1));
    check("both_fetch_bus_addr", 64'(bus_addr), 64'(32'h8));
    check("both_if_stall_bus",   64'(if_id_stall_h), 64'(1));
    bus_ready = 1'b1;
    bus_rdata = 32'h00A0_0113;
    step();
    bus_ready = 1'b0;
    expect_grant("both_fetch");
    if_req = 1'b0;
    step();
    check("both_bus_idle", 64'(bus_req), 64'(0));

    // Store: command latched and stable while waiting
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0200;
    mem_wdata = 32'hDEAD_BEEF;
    mem_be    = 4'b0011;
    sb.push_back('{is_mem: 1'b1, rdata: 32'h0});
    step();
    mem_addr  = 32'h0000_0FFC;
    mem_wdata = 32'h1111_2222;
    mem_be    = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      check("st_bus_req",   64'(bus_req),   64'(1));
      check("st_bus_we",    64'(bus_we),    64'(1));
      check("st_bus_addr",  64'(bus_addr),  64'(32'h200));
      check("st_bus_wdata", 64'(bus_wdata), 64'(32'hDEAD_BEEF));
      check("st_bus_be",    64'(bus_be),    64'(4'b0011));
      step();
    end
    bus_ready = 1'b1;
    bus_rdata = 32'h0;
    step();
    bus_ready = 1'b0;
    expect_grant("store");
    mem_req = 1'b0;
    mem_we  = 1'b0;
    step();
    check("st_gnt_pulse", 64'(mem_gnt), 64'(0));

    // Bus never ready: timeout after MAX_WAIT cycles, NOP returned
    if_req  = 1'b1;
    if_addr = 32'h0000_000C;
    sb.push_back('{is_mem: 1'b0, rdata: 32'h0000_0013});
    step();
    check("to_bus_req", 64'(bus_req), 64'(1));
    cnt = 0;
    while (bus_req && cnt < 40) begin
      cnt++;
      step();
    end
    check("to_cycles", 64'(cnt), 64'(15));
    expect_grant("to_fetch");
    check("to_err", 64'(timeout_err), 64'(1));
    if_req = 1'b0;
    step();
    mem_req  = 1'b1;
    mem_addr = 32'h0000_0300;
    sb.push_back('{is_mem: 1'b1, rdata: 32'h1234_5678});
    step();
    step();
    bus_ready = 1'b1;
    bus_rdata = 32'h1234_5678;
    step();
    bus_ready = 1'b0;
    expect_grant("after_to_load");
    check("to_err_sticky", 64'(timeout_err), 64'(1));
    mem_req = 1'b0;
    step();

    // Clock-enable freeze inside BUS_MEM: timeout delayed by the frozen cycles
    mem_req  = 1'b1;
    mem_addr = 32'h0000_0400;
    sb.push_back('{is_mem: 1'b1, rdata: 32'h0});
    step();
    cnt = 0;
    while (bus_req && cnt < 40) begin
      cnt++;
      if (cnt == 3) clk_en = 1'b0;
      if (cnt == 6) begin
        check("frz_bus_addr", 64'(bus_addr), 64'(32'h400));
        check("frz_mem_gnt",  64'(mem_gnt),  64'(0));
      end
      if (cnt == 7) clk_en = 1'b1;
      step();
    end
    check("frz_cycles", 64'(cnt), 64'(19));
    expect_grant("frz_timeout");
    clk_en  = 1'b0;
    mem_req = 1'b0;
    step();
    check("frz_gnt_ext1", 64'(mem_gnt), 64'(1));
    step();
    check("frz_gnt_ext2", 64'(mem_gnt), 64'(1));
    clk_en = 1'b1;
    step();
    check("frz_gnt_done", 64'(mem_gnt), 64'(0));

    // Asynchronous reset mid-access
    if_req  = 1'b1;
    if_addr = 32'h0000_0500;
    step();
    check("ar_bus_req_pre", 64'(bus_req), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("ar_bus_req", 64'(bus_req), 64'(0));
    check("ar_timeout", 64'(timeout_err), 64'(0));
    if_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Fetch after reset completes normally
    if_req  = 1'b1;
    if_addr = 32'h0000_0600;
    sb.push_back('{is_mem: 1'b0, rdata: 32'h0010_0073});
    step();
    check("pr_bus_addr", 64'(bus_addr), 64'(32'h600));
    bus_ready = 1'b1;
    bus_rdata = 32'h0010_0073;
    step();
    bus_ready = 1'b0;
    expect_grant("post_reset_fetch");
    if_req = 1'b0;
    step();
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
